// File: rtl/mp_rpcs_usb4_pkg.sv
// Shared rate codes, Rx FSM state type and default parameters for the USB4 PIPE6 Rx datapath.
package mp_rpcs_usb4_pkg;

  localparam logic [1:0] RATE_GEN2 = 2'b00;
  localparam logic [1:0] RATE_GEN3 = 2'b01;
  localparam logic [1:0] RATE_GEN4 = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StSettle = 2'd1,
    StOn     = 2'd2
  } rx_state_e;

  localparam int unsigned NUM_SYM_DEF   = 4;
  localparam int unsigned SYM_W_DEF     = 8;
  localparam int unsigned PAD_W_DEF     = 2;
  localparam int unsigned VALID_DLY_DEF = 4;

endpackage

// File: rtl/phy_data_sync.sv
// Two-flop synchroniser for a single-bit level crossing into the local clock domain.
module phy_data_sync #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mp_rpcs_pipe6_usb4_rxdp.sv
// USB4 PIPE6 Rx datapath: PMA symbol padding, Gen4 two-word gearbox and settle-timed RxValid.
module mp_rpcs_pipe6_usb4_rxdp
  import mp_rpcs_usb4_pkg::*;
#(
  parameter int unsigned NUM_SYM   = NUM_SYM_DEF,
  parameter int unsigned SYM_W     = SYM_W_DEF,
  parameter int unsigned PAD_W     = PAD_W_DEF,
  parameter int unsigned VALID_DLY = VALID_DLY_DEF
) (
  input  logic                                    rx_rd_clk,
  input  logic                                    rx_rd_clk_rst_n,
  input  logic                                    rx_en,
  input  logic [1:0]                              pipe_rate,
  input  logic                                    override_en,
  input  logic [NUM_SYM*SYM_W-1:0]                pma_rx_rd,
  output logic [2*NUM_SYM*(SYM_W+PAD_W)-1:0]      pipe_rx_data,
  output logic                                    pipe_rx_valid,
  output logic                                    pipe_rx_data_valid,
  output logic                                    rate_err
);

  localparam int unsigned DW = NUM_SYM * SYM_W;
  localparam int unsigned FW = SYM_W + PAD_W;
  localparam int unsigned PW = NUM_SYM * FW;
  localparam int unsigned CW = $clog2(VALID_DLY + 1);

  // Entry from OFF counts VALID_DLY cycles in SETTLE; a change event adds one cycle for the
  // edge on which it is detected, so RxValid stays low VALID_DLY+1 cycles.
  localparam logic [CW-1:0] CNT_START  = CW'(VALID_DLY - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(VALID_DLY);

  function automatic logic [PW-1:0] pad_word(input logic [DW-1:0] w);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_SYM); i++) begin
      r[i*FW +: FW] = {{PAD_W{1'b0}}, w[i*SYM_W +: SYM_W]};
    end
    return r;
  endfunction

  logic            rx_en_s;
  logic [1:0]      rate_q;
  logic            ovr_q;
  logic [DW-1:0]   pma_q;
  logic [DW-1:0]   hold_q, hold_d;
  logic [2*PW-1:0] data_q, data_d;
  logic            phase_q, phase_d;
  logic            strobe_d;
  logic            valid_q, valid_d;
  logic            data_valid_q;
  logic            rate_err_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  rx_state_e       state_q, state_d;
  logic            chg;
  logic            gen4;

  phy_data_sync #(
    .RESET_VALUE (1'b0)
  ) u_rx_en_sync (
    .clk   (rx_rd_clk),
    .rst_n (rx_rd_clk_rst_n),
    .d     (rx_en),
    .q     (rx_en_s)
  );

  assign chg  = (pipe_rate != rate_q) || (override_en != ovr_q);
  assign gen4 = !ovr_q && (rate_q == RATE_GEN4);

  // RxValid FSM next state: disable wins over change events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!rx_en_s) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOff: begin
          state_d = StSettle;
          cnt_d   = CNT_START;
        end
        StSettle: begin
          if (chg) begin
            cnt_d = CNT_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = StOn;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        StOn: begin
          if (chg) begin
            state_d = StSettle;
            cnt_d   = CNT_RELOAD;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Data mapping and Gen4 gearbox; phase only advances while staying in ON.
  always_comb begin
    data_d   = data_q;
    hold_d   = hold_q;
    strobe_d = 1'b1;
    phase_d  = 1'b0;
    valid_d  = (state_d == StOn);
    if (ovr_q) begin
      data_d = {{(2*PW-DW){1'b0}}, pma_q};
    end else if (gen4) begin
      strobe_d = phase_q;
      if (!phase_q) begin
        hold_d = pma_q;
      end else begin
        data_d = {pad_word(pma_q), pad_word(hold_q)};
      end
      phase_d = (state_q == StOn) && (state_d == StOn) ? ~phase_q : 1'b0;
    end else begin
      data_d = {{PW{1'b0}}, pad_word(pma_q)};
    end
  end

  // All state in the recovered-clock domain.
  always_ff @(posedge rx_rd_clk or negedge rx_rd_clk_rst_n) begin
    if (!rx_rd_clk_rst_n) begin
      rate_q       <= RATE_GEN2;
      ovr_q        <= 1'b0;
      pma_q        <= '0;
      hold_q       <= '0;
      data_q       <= '0;
      phase_q      <= 1'b0;
      valid_q      <= 1'b0;
      data_valid_q <= 1'b0;
      rate_err_q   <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StOff;
    end else begin
      rate_q       <= pipe_rate;
      ovr_q        <= override_en;
      pma_q        <= pma_rx_rd;
      hold_q       <= hold_d;
      data_q       <= data_d;
      phase_q      <= phase_d;
      valid_q      <= valid_d;
      data_valid_q <= valid_d & strobe_d;
      rate_err_q   <= (pipe_rate == RATE_RSVD);
      cnt_q        <= cnt_d;
      state_q      <= state_d;
    end
  end

  assign pipe_rx_data       = data_q;
  assign pipe_rx_valid      = valid_q;
  assign pipe_rx_data_valid = data_valid_q;
  assign rate_err           = rate_err_q;

endmodule

// File: tb/tb_mp_rpcs_pipe6_usb4_rxdp.sv
// Directed bench for the USB4 PIPE6 Rx datapath at default parameters.
module tb_mp_rpcs_pipe6_usb4_rxdp;

  localparam logic [79:0] EXP_G2A  = {40'h0, 10'h044, 10'h033, 10'h022, 10'h011};
  localparam logic [79:0] EXP_G2B  = {40'h0, 10'h088, 10'h077, 10'h066, 10'h055};
  localparam logic [79:0] EXP_PAIR = {10'h0B3, 10'h0B2, 10'h0B1, 10'h0B0,
                                      10'h0A3, 10'h0A2, 10'h0A1, 10'h0A0};
  localparam logic [79:0] EXP_OVR  = 80'h0000_0000_0000_DEAD_BEEF;
  localparam logic [31:0] WORD_A   = 32'hA3A2A1A0;
  localparam logic [31:0] WORD_B   = 32'hB3B2B1B0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic [1:0]  pipe_rate = 2'b00;
  logic        override_en = 1'b0;
  logic [31:0] pma = 32'h0;
  logic [79:0] pipe_rx_data;
  logic        pipe_rx_valid;
  logic        pipe_rx_data_valid;
  logic        rate_err;

  int n_tests = 0;
  int n_fail  = 0;

  mp_rpcs_pipe6_usb4_rxdp dut (
    .rx_rd_clk          (clk),
    .rx_rd_clk_rst_n    (rst_n),
    .rx_en              (rx_en),
    .pipe_rate          (pipe_rate),
    .override_en        (override_en),
    .pma_rx_rd          (pma),
    .pipe_rx_data       (pipe_rx_data),
    .pipe_rx_valid      (pipe_rx_valid),
    .pipe_rx_data_valid (pipe_rx_data_valid),
    .rate_err           (rate_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", pipe_rx_valid); end
    n_tests++; if (pipe_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b exp 0", pipe_rx_data_valid); end
    n_tests++; if (pipe_rx_data !== 80'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", pipe_rx_data); end
    n_tests++; if (rate_err !== 1'b0) begin n_fail++; $display("FAIL reset_rate_err got %b exp 0", rate_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_gen2_settle();
    rx_en = 1'b1; pipe_rate = 2'b00; pma = 32'h44332211;
    for (int e = 1; e <= 6; e++) tick();
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL g2_valid_e6 got %b exp 0", pipe_rx_valid); end
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL g2_valid_e7 got %b exp 1", pipe_rx_valid); end
    n_tests++; if (pipe_rx_data !== EXP_G2A) begin n_fail++; $display("FAIL g2_data_a got %h exp %h", pipe_rx_data, EXP_G2A); end
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL g2_dv_e7 got %b exp 1", pipe_rx_data_valid); end
    pma = 32'h88776655;
    tick();
    n_tests++; if (pipe_rx_data !== EXP_G2A) begin n_fail++; $display("FAIL g2_latency got %h exp %h", pipe_rx_data, EXP_G2A); end
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL g2_dv_e8 got %b exp 1", pipe_rx_data_valid); end
    tick();
    n_tests++; if (pipe_rx_data !== EXP_G2B) begin n_fail++; $display("FAIL g2_data_b got %h exp %h", pipe_rx_data, EXP_G2B); end
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL g2_dv_e9 got %b exp 1", pipe_rx_data_valid); end
  endtask

  task automatic test_gen4_switch();
    int highs;
    highs = 0;
    pma = WORD_A; pipe_rate = 2'b10;
    for (int i = 0; i < 5; i++) begin tick(); if (pipe_rx_valid !== 1'b0) highs++; end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL g4_settle_low got %0d high cycles exp 0", highs); end
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL g4_valid_back got %b exp 1", pipe_rx_valid); end
    pma = WORD_B;
    tick();
    n_tests++; if (pipe_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL g4_phase0_dv got %b exp 0", pipe_rx_data_valid); end
    tick();
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL g4_pair_dv got %b exp 1", pipe_rx_data_valid); end
    n_tests++; if (pipe_rx_data !== EXP_PAIR) begin n_fail++; $display("FAIL g4_pair_data got %h exp %h", pipe_rx_data, EXP_PAIR); end
    tick();
    n_tests++; if (pipe_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL g4_hold_dv got %b exp 0", pipe_rx_data_valid); end
    n_tests++; if (pipe_rx_data !== EXP_PAIR) begin n_fail++; $display("FAIL g4_hold_data got %h exp %h", pipe_rx_data, EXP_PAIR); end
  endtask

  task automatic test_override();
    int highs;
    highs = 0;
    override_en = 1'b1; pma = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin tick(); if (pipe_rx_valid !== 1'b0) highs++; end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL ovr_settle_low got %0d high cycles exp 0", highs); end
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", pipe_rx_valid); end
    n_tests++; if (pipe_rx_data !== EXP_OVR) begin n_fail++; $display("FAIL ovr_data got %h exp %h", pipe_rx_data, EXP_OVR); end
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_dv got %b exp 1", pipe_rx_data_valid); end
    override_en = 1'b0;
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_off_drop got %b exp 0", pipe_rx_valid); end
    for (int i = 0; i < 4; i++) tick();
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_off_resettle got %b exp 1", pipe_rx_valid); end
  endtask

  task automatic test_rate_err();
    pipe_rate = 2'b11; pma = 32'h44332211;
    tick();
    n_tests++; if (rate_err !== 1'b1) begin n_fail++; $display("FAIL rsvd_rate_err got %b exp 1", rate_err); end
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_valid_drop got %b exp 0", pipe_rx_valid); end
    for (int i = 0; i < 4; i++) tick();
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL rsvd_valid got %b exp 1", pipe_rx_valid); end
    n_tests++; if (pipe_rx_data !== EXP_G2A) begin n_fail++; $display("FAIL rsvd_data got %h exp %h", pipe_rx_data, EXP_G2A); end
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL rsvd_dv got %b exp 1", pipe_rx_data_valid); end
    pipe_rate = 2'b00;
    tick();
    n_tests++; if (rate_err !== 1'b0) begin n_fail++; $display("FAIL rsvd_clear got %b exp 0", rate_err); end
    for (int i = 0; i < 4; i++) tick();
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL g2_back_valid got %b exp 1", pipe_rx_valid); end
  endtask

  task automatic test_rx_en_drop();
    int highs;
    highs = 0;
    rx_en = 1'b0;
    tick(); tick();
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL drop_e2 got %b exp 1", pipe_rx_valid); end
    tick();
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL drop_e3 got %b exp 0", pipe_rx_valid); end
    rx_en = 1'b1;
    tick(); tick(); tick();
    rx_en = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (pipe_rx_valid !== 1'b0) highs++; end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL settle_abort got %0d high cycles exp 0", highs); end
  endtask

  task automatic test_async_reset();
    rx_en = 1'b1; pipe_rate = 2'b10; pma = WORD_A;
    for (int i = 0; i < 40; i++) begin tick(); if (pipe_rx_valid) break; end
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got %b exp 1", pipe_rx_valid); end
    pma = WORD_B;
    tick(); tick();
    n_tests++; if (pipe_rx_data !== EXP_PAIR) begin n_fail++; $display("FAIL ar_pre_pair got %h exp %h", pipe_rx_data, EXP_PAIR); end
    tick();
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (pipe_rx_data !== 80'h0) begin n_fail++; $display("FAIL ar_data got %h exp 0", pipe_rx_data); end
    n_tests++; if (pipe_rx_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", pipe_rx_valid); end
    n_tests++; if (pipe_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL ar_dv got %b exp 0", pipe_rx_data_valid); end
    tick(); tick();
    rst_n = 1'b1; pma = WORD_A;
    for (int i = 0; i < 40; i++) begin tick(); if (pipe_rx_valid) break; end
    n_tests++; if (pipe_rx_valid !== 1'b1) begin n_fail++; $display("FAIL ar_post_valid got %b exp 1", pipe_rx_valid); end
    pma = WORD_B;
    tick();
    n_tests++; if (pipe_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL ar_phase0_dv got %b exp 0", pipe_rx_data_valid); end
    tick();
    n_tests++; if (pipe_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pair_dv got %b exp 1", pipe_rx_data_valid); end
    n_tests++; if (pipe_rx_data !== EXP_PAIR) begin n_fail++; $display("FAIL ar_pair_data got %h exp %h", pipe_rx_data, EXP_PAIR); end
  endtask

  initial begin
    test_reset();
    test_gen2_settle();
    test_gen4_switch();
    test_override();
    test_rate_err();
    test_rx_en_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
